// File: rtl/ep2_pkg.sv
// Shared types and frame geometry for the EP2 receive-side frame decoder.
package ep2_pkg;

  localparam int unsigned FRAME_BYTES  = 512;
  localparam int unsigned CC_BYTES     = 5;
  localparam int unsigned SAMPLE_BYTES = 8;
  localparam int unsigned SYNC_LEN     = 3;
  localparam int unsigned WORD_W       = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CC     = 2'd1,
    SAMPLE = 2'd2,
    SYNC   = 2'd3
  } ep2_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] audio_l;
    logic [WORD_W-1:0] audio_r;
    logic [WORD_W-1:0] tx_i;
    logic [WORD_W-1:0] tx_q;
  } ep2_sample_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic        mox;
    logic [31:0] data;
  } ep2_cc_t;

endpackage

// File: rtl/ep2_sample_assembler.sv
// Collects the 8 bytes of one EP2 sample and presents them as four big-endian
// 16-bit words behind a valid/ready output register.
module ep2_sample_assembler
  import ep2_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             byte_stb_i,
  input  logic [7:0]                       byte_i,
  input  logic                             sample_ready_i,
  output logic [$clog2(SAMPLE_BYTES)-1:0]  byte_idx_o,
  output logic                             sample_valid_o,
  output logic [WORD_W-1:0]                audio_l_o,
  output logic [WORD_W-1:0]                audio_r_o,
  output logic [WORD_W-1:0]                tx_i_o,
  output logic [WORD_W-1:0]                tx_q_o
);

  localparam int unsigned IDX_W   = $clog2(SAMPLE_BYTES);
  localparam int unsigned STAGE_W = 8 * (SAMPLE_BYTES - 1);

  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  ep2_sample_t        smp_q, smp_d;
  logic               valid_q, valid_d;
  logic               last_byte_c;

  // Byte 0 ends up in the top of the staging shift register.
  always_comb begin
    last_byte_c = byte_stb_i && (byte_idx_q == IDX_W'(SAMPLE_BYTES - 1));
    byte_idx_d  = byte_idx_q;
    stage_d     = stage_q;
    smp_d       = smp_q;
    valid_d     = valid_q;
    if (byte_stb_i) begin
      byte_idx_d = last_byte_c ? '0 : byte_idx_q + IDX_W'(1);
      stage_d    = {stage_q[STAGE_W-9:0], byte_i};
    end
    if (last_byte_c) begin
      smp_d   = ep2_sample_t'({stage_q, byte_i});
      valid_d = 1'b1;
    end else if (sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      stage_q    <= '0;
      smp_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      stage_q    <= stage_d;
      smp_q      <= smp_d;
      valid_q    <= valid_d;
    end
  end

  assign byte_idx_o     = byte_idx_q;
  assign sample_valid_o = valid_q;
  assign audio_l_o      = smp_q.audio_l;
  assign audio_r_o      = smp_q.audio_r;
  assign tx_i_o         = smp_q.tx_i;
  assign tx_q_o         = smp_q.tx_q;

endmodule

// File: rtl/ep2_frame_decoder.sv
// EP2 frame decoder: locks onto 512-byte frames from the Rx FIFO, publishes
// C&C words and per-sample audio / TX I/Q, and tracks sync losses.
module ep2_frame_decoder
  import ep2_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_FRAME = (FRAME_BYTES - SYNC_LEN - CC_BYTES) / SAMPLE_BYTES,
  parameter logic [7:0]  SYNC_BYTE         = 8'h7F,
  parameter int unsigned ERR_W             = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic              cc_valid,
  output logic [6:0]        cc_addr,
  output logic [31:0]       cc_data,
  output logic              mox,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [15:0]       audio_l,
  output logic [15:0]       audio_r,
  output logic [15:0]       tx_i,
  output logic [15:0]       tx_q,
  output logic              synced,
  output logic [ERR_W-1:0]  sync_err_cnt
);

  localparam int unsigned SMP_W    = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam int unsigned RUN_W    = $clog2(SYNC_LEN);
  localparam int unsigned CC_IDX_W = $clog2(CC_BYTES);
  localparam int unsigned IDX_W    = $clog2(SAMPLE_BYTES);

  ep2_state_e            state_q, state_d;
  logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0]      sync_idx_q, sync_idx_d;
  logic [CC_IDX_W-1:0]   cc_idx_q, cc_idx_d;
  logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
  logic [31:0]           cc_stage_q, cc_stage_d;
  ep2_cc_t               cc_q, cc_d;
  logic                  cc_valid_q, cc_valid_d;
  logic                  synced_q, synced_d;
  logic [ERR_W-1:0]      err_q, err_d;

  logic                  consume_c;
  logic                  is_sync_c;
  logic                  smp_stb_c;
  logic [IDX_W-1:0]      byte_idx;

  // A held, unaccepted sample is the only back-pressure on the FIFO.
  assign fifo_rdreq = !fifo_empty && !(sample_valid && !sample_ready);
  assign consume_c  = fifo_rdreq;
  assign is_sync_c  = (fifo_data == SYNC_BYTE);
  assign smp_stb_c  = consume_c && (state_q == SAMPLE);

  ep2_sample_assembler u_asm (
    .clk            (clk),
    .rst            (rst),
    .byte_stb_i     (smp_stb_c),
    .byte_i         (fifo_data),
    .sample_ready_i (sample_ready),
    .byte_idx_o     (byte_idx),
    .sample_valid_o (sample_valid),
    .audio_l_o      (audio_l),
    .audio_r_o      (audio_r),
    .tx_i_o         (tx_i),
    .tx_q_o         (tx_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state and frame position counters; everything advances on consumed bytes only.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    sync_idx_d = sync_idx_q;
    cc_idx_d   = cc_idx_q;
    smp_cnt_d  = smp_cnt_q;
    if (consume_c) begin
      case (state_q)
        HUNT: begin
          if (!is_sync_c) begin
            run_cnt_d = '0;
          end else if (run_cnt_q == RUN_W'(SYNC_LEN - 1)) begin
            run_cnt_d = '0;
            state_d   = CC;
          end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
        end
        CC: begin
          if (cc_idx_q == CC_IDX_W'(CC_BYTES - 1)) begin
            cc_idx_d = '0;
            state_d  = SAMPLE;
          end else begin
            cc_idx_d = cc_idx_q + CC_IDX_W'(1);
          end
        end
        SAMPLE: begin
          if (byte_idx == IDX_W'(SAMPLE_BYTES - 1)) begin
            if (smp_cnt_q == SMP_W'(SAMPLES_PER_FRAME - 1)) begin
              smp_cnt_d  = '0;
              sync_idx_d = '0;
              state_d    = SYNC;
            end else begin
              smp_cnt_d = smp_cnt_q + SMP_W'(1);
            end
          end
        end
        SYNC: begin
          if (!is_sync_c) begin
            sync_idx_d = '0;
            run_cnt_d  = '0;
            state_d    = HUNT;
          end else if (sync_idx_q == RUN_W'(SYNC_LEN - 1)) begin
            sync_idx_d = '0;
            state_d    = CC;
          end else begin
            sync_idx_d = sync_idx_q + RUN_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // C&C capture, lock flag and sync-error counter.
  always_comb begin
    cc_stage_d = cc_stage_q;
    cc_d       = cc_q;
    cc_valid_d = 1'b0;
    synced_d   = synced_q;
    err_d      = err_q;
    if (consume_c && (state_q == CC)) begin
      if (cc_idx_q == CC_IDX_W'(CC_BYTES - 1)) begin
        cc_d.addr  = cc_stage_q[31:25];
        cc_d.mox   = cc_stage_q[24];
        cc_d.data  = {cc_stage_q[23:0], fifo_data};
        cc_valid_d = 1'b1;
      end else begin
        cc_stage_d = {cc_stage_q[23:0], fifo_data};
      end
    end
    if (consume_c && (state_q == SYNC) && !is_sync_c) begin
      synced_d = 1'b0;
      err_d    = (&err_q) ? err_q : err_q + ERR_W'(1);
    end
    if ((state_d == CC) && (state_q != CC)) begin
      synced_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q  <= '0;
      sync_idx_q <= '0;
      cc_idx_q   <= '0;
      smp_cnt_q  <= '0;
      cc_stage_q <= '0;
      cc_q       <= '0;
      cc_valid_q <= 1'b0;
      synced_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      sync_idx_q <= sync_idx_d;
      cc_idx_q   <= cc_idx_d;
      smp_cnt_q  <= smp_cnt_d;
      cc_stage_q <= cc_stage_d;
      cc_q       <= cc_d;
      cc_valid_q <= cc_valid_d;
      synced_q   <= synced_d;
      err_q      <= err_d;
    end
  end

  assign cc_valid     = cc_valid_q;
  assign cc_addr      = cc_q.addr;
  assign mox          = cc_q.mox;
  assign cc_data      = cc_q.data;
  assign synced       = synced_q;
  assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_ep2_frame_decoder.sv
// Scoreboard bench for ep2_frame_decoder: frames are queued as FIFO bytes with
// their expected C&C words and samples; a monitor checks every DUT output.
module tb_ep2_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        cc_valid;
  logic [6:0]  cc_addr;
  logic [31:0] cc_data;
  logic        mox;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] audio_l, audio_r, tx_i, tx_q;
  logic        synced;
  logic [7:0]  sync_err_cnt;

  // Short-frame instance used to reach counter saturation quickly.
  logic [7:0]  s_data;
  logic        s_empty, s_rdreq, s_cc_valid, s_mox, s_sample_valid, s_ready, s_synced;
  logic [6:0]  s_cc_addr;
  logic [31:0] s_cc_data;
  logic [15:0] s_al, s_ar, s_ti, s_tq;
  logic [7:0]  s_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  bq[$];
  logic [39:0] exp_cc[$];
  logic [63:0] exp_smp[$];
  bit          gap_en = 1'b0;
  bit          pend   = 1'b0;

  always #5 clk = ~clk;

  ep2_frame_decoder dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .cc_valid(cc_valid), .cc_addr(cc_addr), .cc_data(cc_data),
    .mox(mox), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .audio_l(audio_l), .audio_r(audio_r), .tx_i(tx_i), .tx_q(tx_q),
    .synced(synced), .sync_err_cnt(sync_err_cnt)
  );

  ep2_frame_decoder #(.SAMPLES_PER_FRAME(2)) dut_short (
    .clk(clk), .rst(rst), .fifo_data(s_data), .fifo_empty(s_empty),
    .fifo_rdreq(s_rdreq), .cc_valid(s_cc_valid), .cc_addr(s_cc_addr), .cc_data(s_cc_data),
    .mox(s_mox), .sample_valid(s_sample_valid), .sample_ready(s_ready),
    .audio_l(s_al), .audio_r(s_ar), .tx_i(s_ti), .tx_q(s_tq),
    .synced(s_synced), .sync_err_cnt(s_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Sample k of frame fid: bytes {fid, 4k+1, fid, 4k+2, fid, 4k+3, fid, 4k+4}.
  function automatic logic [63:0] samp(input int fid, input int k);
    return {8'(fid), 8'(4*k+1), 8'(fid), 8'(4*k+2), 8'(fid), 8'(4*k+3), 8'(fid), 8'(4*k+4)};
  endfunction

  task automatic push_frame(input int fid, input logic [7:0] c0, input bit bad_sync,
                            input bit expect_out, input int nbytes);
    logic [7:0]  b[$];
    logic [63:0] s;
    logic [7:0]  c4;
    c4 = 8'(8'h78 + fid);
    b  = {};
    b.push_back(8'h7F);
    b.push_back(bad_sync ? 8'h7E : 8'h7F);
    b.push_back(8'h7F);
    b.push_back(c0);
    b.push_back(8'h12);
    b.push_back(8'h34);
    b.push_back(8'h56);
    b.push_back(c4);
    for (int k = 0; k < 63; k++) begin
      s = samp(fid, k);
      for (int j = 0; j < 8; j++) b.push_back(s[63-8*j -: 8]);
    end
    if (expect_out) begin
      if (nbytes >= 8) exp_cc.push_back({c0[7:1], c0[0], 24'h123456, c4});
      for (int k = 0; k < 63; k++)
        if (nbytes >= 8 + 8*(k+1)) exp_smp.push_back(samp(fid, k));
    end
    for (int i = 0; i < nbytes; i++) bq.push_back(b[i]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (bq.size() == 0 && exp_cc.size() == 0 && exp_smp.size() == 0) return;
    end
    fail_now(name);
  endtask

  // Show-ahead FIFO model: inputs change on negedge, a byte leaves after a posedge with rdreq.
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = 8'h7F;
    forever begin
      @(negedge clk);
      if (pend && bq.size() > 0) void'(bq.pop_front());
      pend       = 1'b0;
      fifo_empty = (bq.size() == 0) || (gap_en && $urandom_range(0, 1) == 1);
      fifo_data  = fifo_empty ? 8'h7F : bq[0];
      #1;
      pend = fifo_rdreq;
    end
  end

  // Monitor: every C&C pulse and every accepted sample is popped and compared.
  initial begin
    logic [39:0] ec;
    logic [63:0] es;
    forever begin
      @(negedge clk); #2;
      if (!rst && cc_valid) begin
        if (exp_cc.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cc_unexpected: got addr %h mox %b data %h, required none", cc_addr, mox, cc_data);
        end else begin
          ec = exp_cc.pop_front();
          check("cc_word", {24'h0, cc_addr, mox, cc_data}, {24'h0, ec});
        end
      end
      if (!rst && sample_valid && sample_ready) begin
        if (exp_smp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL smp_unexpected: got %h %h %h %h, required none", audio_l, audio_r, tx_i, tx_q);
        end else begin
          es = exp_smp.pop_front();
          check("sample", {audio_l, audio_r, tx_i, tx_q}, es);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sb[$];
    logic [63:0] s;
    bit seen;
    rst = 1'b1; sample_ready = 1'b1;
    s_empty = 1'b1; s_data = 8'h00; s_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("reset_cc", {cc_valid, cc_addr, mox, cc_data}, 64'h0);
    check("reset_smp", {audio_l, audio_r, tx_i, tx_q}, 64'h0);
    check("reset_status", {sample_valid, synced, sync_err_cnt, fifo_rdreq}, 64'h0);
    @(negedge clk); rst = 1'b0;

    // Clean frame
    push_frame(0, 8'h01, 1'b0, 1'b1, 512);
    wait_drain("drain_f1", 2000);
    check("f1_synced", synced, 1);
    check("f1_err", sync_err_cnt, 0);

    // Back-to-back frame with C0 equal to the sync byte
    push_frame(1, 8'h7F, 1'b0, 1'b1, 512);
    wait_drain("drain_f2", 2000);
    check("f2_synced", synced, 1);
    check("f2_err", sync_err_cnt, 0);

    // Corrupted second sync byte: lock lost, nothing decoded
    push_frame(2, 8'h01, 1'b1, 1'b0, 512);
    wait_drain("drain_f3", 2000);
    repeat (2) @(negedge clk); #3;
    check("f3_synced", synced, 0);
    check("f3_err", sync_err_cnt, 1);

    push_frame(3, 8'h01, 1'b0, 1'b1, 512);
    wait_drain("drain_f4", 2000);
    check("f4_synced", synced, 1);
    check("f4_err", sync_err_cnt, 1);

    // Downstream stall on the first sample
    @(negedge clk); sample_ready = 1'b0;
    push_frame(4, 8'h05, 1'b0, 1'b1, 512);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #3;
      seen = sample_valid;
    end
    if (!seen) fail_now("stall_wait_valid");
    repeat (20) begin
      @(negedge clk); #3;
      check("stall_rdreq", {sample_valid, fifo_rdreq}, 64'h2);
      check("stall_hold", {audio_l, audio_r, tx_i, tx_q}, samp(4, 0));
    end
    @(negedge clk); sample_ready = 1'b1;
    wait_drain("drain_f5", 2000);

    // Random FIFO-empty gaps
    gap_en = 1'b1;
    push_frame(5, 8'h02, 1'b0, 1'b1, 512);
    wait_drain("drain_f6", 4000);
    gap_en = 1'b0;

    // Reset mid-sample 30
    push_frame(6, 8'h01, 1'b0, 1'b1, 8 + 8*30 + 4);
    wait_drain("drain_f7", 2000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #3;
    check("rst_cc", {cc_valid, cc_addr, mox, cc_data}, 64'h0);
    check("rst_smp", {audio_l, audio_r, tx_i, tx_q}, 64'h0);
    check("rst_status", {sample_valid, synced, sync_err_cnt}, 64'h0);

    push_frame(7, 8'h01, 1'b0, 1'b1, 512);
    wait_drain("drain_f8", 2000);
    check("f8_synced", synced, 1);
    check("f8_err", sync_err_cnt, 0);

    // Saturation: 300 lock/lose cycles on the short-frame instance
    sb = {8'h7F, 8'h7F, 8'h7F, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int k = 0; k < 2; k++) begin
      s = samp(0, k);
      for (int j = 0; j < 8; j++) sb.push_back(s[63-8*j -: 8]);
    end
    sb.push_back(8'h00);
    @(negedge clk); s_empty = 1'b0;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < sb.size(); j++) begin
        @(negedge clk); s_data = sb[j];
      end
      if (i == 9 || i == 253 || i == 254 || i == 255 || i == 299) begin
        @(negedge clk); #3;
        check("sat_cnt", s_err, (i + 1 > 255) ? 255 : i + 1);
      end
    end
    s_empty = 1'b1;

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
